// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_layer_sequencer
//  Description : Runs a chain of CNN layer engines in ascending index order.
//                Holds the engines in reset for two cycles, then pulses each
//                enabled layer's start and waits for its sticky done. A
//                per-layer watchdog turns a stalled layer into an error.
//                Abort drops the engines back into reset and returns to idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int TO_W       = 24
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cmd_start,
    input  logic                          cmd_abort,
    input  logic [NUM_LAYERS-1:0]         layer_mask,
    input  logic [TO_W-1:0]               timeout_limit,
    input  logic [NUM_LAYERS-1:0]         layer_done,
    output logic [NUM_LAYERS-1:0]         layer_start,
    output logic                          layer_resetn,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic                          irq,
    output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
    output logic [$clog2(NUM_LAYERS)-1:0] err_layer,
    output logic [31:0]                   cycle_count
);

    localparam int LAYER_W = $clog2(NUM_LAYERS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5,
        S_ABORT = 3'd6
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  phase;       // second cycle of the two-cycle RST/ABORT states
    logic                  accept;
    logic [LAYER_W-1:0]    next_cur;
    logic [LAYER_W:0]      sel;         // {found, index} from the mask search
    logic [NUM_LAYERS-1:0] mask_q;
    logic [TO_W-1:0]       limit_q;
    logic [TO_W-1:0]       watchdog;
    logic                  run_phase;

    // Lowest set bit of m whose index is at least 'from'; MSB flags a hit.
    function automatic logic [LAYER_W:0] find_from(input logic [NUM_LAYERS-1:0] m,
                                                   input int from);
        logic [LAYER_W:0] r;
        r = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) begin
                r = {1'b1, LAYER_W'(i)};
            end
        end
        return r;
    endfunction

    assign run_phase = (state == S_RST) || (state == S_START) || (state == S_WAIT);

    // State register; phase marks the second cycle spent in the same state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            phase <= 1'b0;
        end else begin
            state <= next_state;
            phase <= (next_state == state);
        end
    end

    // Next-state decode: abort beats everything, layer done beats the watchdog.
    always_comb begin
        next_state = state;
        next_cur   = cur_layer;
        accept     = 1'b0;
        sel        = '0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (cmd_start && !cmd_abort) begin
                    accept     = 1'b1;
                    next_state = S_RST;
                end
            end
            S_RST: begin
                if (cmd_abort) begin
                    next_state = S_ABORT;
                end else if (phase) begin
                    sel = find_from(mask_q, 0);
                    if (sel[LAYER_W]) begin
                        next_state = S_START;
                        next_cur   = sel[LAYER_W-1:0];
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            S_START: begin
                next_state = cmd_abort ? S_ABORT : S_WAIT;
            end
            S_WAIT: begin
                if (cmd_abort) begin
                    next_state = S_ABORT;
                end else if (layer_done[cur_layer]) begin
                    sel = find_from(mask_q, int'(cur_layer) + 1);
                    if (sel[LAYER_W]) begin
                        next_state = S_START;
                        next_cur   = sel[LAYER_W-1:0];
                    end else begin
                        next_state = S_DONE;
                    end
                end else if ((limit_q != '0) && (watchdog == limit_q - TO_W'(1))) begin
                    next_state = S_ERROR;
                end
            end
            S_ABORT: begin
                if (phase) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Registered outputs and run context, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mask_q       <= '0;
            limit_q      <= '0;
            watchdog     <= '0;
            layer_start  <= '0;
            layer_resetn <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            irq          <= 1'b0;
            cur_layer    <= '0;
            err_layer    <= '0;
            cycle_count  <= '0;
        end else begin
            if (accept) begin
                mask_q  <= layer_mask;
                limit_q <= timeout_limit;
            end
            watchdog     <= ((state == S_WAIT) && (next_state == S_WAIT)) ? watchdog + TO_W'(1) : '0;
            layer_start  <= (next_state == S_START) ? (NUM_LAYERS'(1) << next_cur) : '0;
            layer_resetn <= !((next_state == S_RST) || (next_state == S_ABORT));
            busy         <= (next_state == S_RST) || (next_state == S_START) ||
                            (next_state == S_WAIT) || (next_state == S_ABORT);
            done         <= (next_state == S_DONE);
            error        <= (next_state == S_ERROR);
            irq          <= ((next_state == S_DONE) && (state != S_DONE)) ||
                            ((next_state == S_ERROR) && (state != S_ERROR));
            cur_layer    <= next_cur;
            if (accept) begin
                err_layer <= '0;
            end else if ((state == S_WAIT) && (next_state == S_ERROR)) begin
                err_layer <= cur_layer;
            end
            // The accepting cycle is counted as the first cycle of the run.
            if (accept) begin
                cycle_count <= 32'd1;
            end else if (run_phase && (cycle_count != 32'hFFFF_FFFF)) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_layer_sequencer
//  Description : Self-checking bench; expected timelines are computed from
//                the run rules (start/done/timeout schedule) per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_layer_sequencer;

    localparam int N  = 4;
    localparam int TW = 24;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [N-1:0]  layer_mask = '0;
    logic [TW-1:0] timeout_limit = '0;
    logic [N-1:0]  layer_done = '0;
    logic [N-1:0]  layer_start;
    logic          layer_resetn;
    logic          busy, done, error, irq;
    logic [LW-1:0] cur_layer, err_layer;
    logic [31:0]   cycle_count;

    int vectors = 0;
    int miscompares = 0;
    int dly[N];
    int started_cnt[N];
    int prev_cur = 0;
    bit eng_started[N];
    int eng_s[N];

    cnn_layer_sequencer #(.NUM_LAYERS(N), .TO_W(TW)) dut (
        .clk(clk), .resetn(resetn), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .layer_mask(layer_mask), .timeout_limit(timeout_limit), .layer_done(layer_done),
        .layer_start(layer_start), .layer_resetn(layer_resetn), .busy(busy),
        .done(done), .error(error), .irq(irq), .cur_layer(cur_layer),
        .err_layer(err_layer), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // One run from cmd_start; abort_at: -1 none, -2 random, >0 that cycle.
    task automatic run_scenario(input logic [N-1:0] m, input int lim,
                                input int abort_at, input bit noise);
        int exp_s[N];
        int endc, errl, prv, s, a, last, nstop;
        bit is_err, ab;
        logic [N-1:0] st_e, nd;
        int cur_e, cc_e;
        bit busy_e, lrn_e, irq_e, done_e, err_e;
        int errl_e;

        // expected schedule from the layer rules
        is_err = 0; errl = 0; endc = -1; prv = 2;
        for (int i = 0; i < N; i++) begin
            exp_s[i] = -1;
            started_cnt[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (m[i] && endc < 0) begin
                s = prv + 1;
                exp_s[i] = s;
                if (dly[i] != 0 && (lim == 0 || dly[i] <= lim)) prv = s + dly[i];
                else begin
                    endc = s + lim + 1; is_err = 1; errl = i;
                end
            end
        end
        if (endc < 0) endc = prv + 1;
        a = abort_at;
        if (abort_at == -2) a = $urandom_range(1, endc - 1);
        ab = (a > 0) && (a < endc);
        if (ab) begin
            for (int i = 0; i < N; i++) if (exp_s[i] > a) exp_s[i] = -1;
        end
        last  = ab ? a + 4 : endc + 2;
        nstop = ab ? a + 2 : endc - 1;

        @(posedge clk); #1;
        cmd_start = 1'b1; cmd_abort = 1'b0;
        layer_mask = m; timeout_limit = TW'(lim);

        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            cmd_start = 1'b0; cmd_abort = 1'b0;

            busy_e = ab ? (k <= a + 2) : (k < endc);
            lrn_e  = !(k == 1 || k == 2 || (ab && (k == a + 1 || k == a + 2)));
            irq_e  = !ab && (k == endc);
            done_e = !ab && !is_err && (k >= endc);
            err_e  = !ab && is_err && (k >= endc);
            errl_e = err_e ? errl : 0;
            cc_e   = ab ? ((k < a + 1) ? k : a + 1) : ((k < endc) ? k : endc);
            st_e   = '0;
            cur_e  = prev_cur;
            for (int i = 0; i < N; i++) begin
                if (exp_s[i] == k) st_e[i] = 1'b1;
                if (exp_s[i] >= 0 && exp_s[i] <= k) cur_e = i;
            end

            vectors += 9;
            if (busy !== busy_e) begin
                miscompares++; $display("FAIL busy cyc=%0d got=%b want=%b", k, busy, busy_e);
            end
            if (layer_resetn !== lrn_e) begin
                miscompares++; $display("FAIL layer_resetn cyc=%0d got=%b want=%b", k, layer_resetn, lrn_e);
            end
            if (layer_start !== st_e) begin
                miscompares++; $display("FAIL layer_start cyc=%0d got=%b want=%b", k, layer_start, st_e);
            end
            if (irq !== irq_e) begin
                miscompares++; $display("FAIL irq cyc=%0d got=%b want=%b", k, irq, irq_e);
            end
            if (done !== done_e) begin
                miscompares++; $display("FAIL done cyc=%0d got=%b want=%b", k, done, done_e);
            end
            if (error !== err_e) begin
                miscompares++; $display("FAIL error cyc=%0d got=%b want=%b", k, error, err_e);
            end
            if (err_layer !== LW'(errl_e)) begin
                miscompares++; $display("FAIL err_layer cyc=%0d got=%0d want=%0d", k, err_layer, errl_e);
            end
            if (cycle_count !== 32'(cc_e)) begin
                miscompares++; $display("FAIL cycle_count cyc=%0d got=%0d want=%0d", k, cycle_count, cc_e);
            end
            if (cur_layer !== LW'(cur_e)) begin
                miscompares++; $display("FAIL cur_layer cyc=%0d got=%0d want=%0d", k, cur_layer, cur_e);
            end

            // layer engine models: sticky done after their delay, cleared by reset
            for (int i = 0; i < N; i++) begin
                if (layer_start[i]) begin
                    eng_started[i] = 1'b1; eng_s[i] = k; started_cnt[i]++;
                end
                if (!layer_resetn) eng_started[i] = 1'b0;
            end
            nd = '0;
            for (int i = 0; i < N; i++) begin
                if (eng_started[i] && dly[i] != 0 && k >= eng_s[i] + dly[i]) nd[i] = 1'b1;
                else if (noise && layer_resetn && !eng_started[i] && $urandom_range(0, 3) == 0) nd[i] = 1'b1;
            end
            layer_done = nd;
            if (noise && k <= nstop && $urandom_range(0, 3) == 0) cmd_start = 1'b1;
            if (ab && k == a) cmd_abort = 1'b1;
        end
        cmd_start = 1'b0; cmd_abort = 1'b0;
        prev_cur = cur_e;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({layer_start, layer_resetn, busy, done, error, irq, cur_layer, err_layer, cycle_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_values got start=%b lrn=%b busy=%b done=%b err=%b irq=%b cur=%0d errl=%0d cc=%0d want all zero",
                     layer_start, layer_resetn, busy, done, error, irq, cur_layer, err_layer, cycle_count);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (layer_resetn !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL idle_after_reset got lrn=%b busy=%b want lrn=1 busy=0", layer_resetn, busy);
        end
        prev_cur = 0;
    endtask

    task automatic test_full_chain();
        for (int i = 0; i < N; i++) dly[i] = 10;
        run_scenario(4'b1111, 0, -1, 0);
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (started_cnt[i] !== 1) begin
                miscompares++; $display("FAIL full_chain_starts layer=%0d got=%0d want=1", i, started_cnt[i]);
            end
        end
    endtask

    task automatic test_sparse_mask();
        for (int i = 0; i < N; i++) dly[i] = 4 + i;
        run_scenario(4'b1010, 0, -1, 0);
        vectors++;
        if (started_cnt[0] !== 0 || started_cnt[2] !== 0 || started_cnt[1] !== 1 || started_cnt[3] !== 1) begin
            miscompares++;
            $display("FAIL sparse_starts got=%0d,%0d,%0d,%0d want=0,1,0,1",
                     started_cnt[0], started_cnt[1], started_cnt[2], started_cnt[3]);
        end
    endtask

    task automatic test_timeout();
        dly[0] = 0; dly[1] = 3; dly[2] = 3; dly[3] = 3;
        run_scenario(4'b0001, 5, -1, 0);
        dly[0] = 4;                       // done on the watchdog's last cycle wins
        run_scenario(4'b0001, 4, -1, 0);
        dly[0] = 5;                       // one cycle too late
        run_scenario(4'b0001, 4, -1, 0);
        dly[0] = 2; dly[2] = 0;
        run_scenario(4'b0101, 1, -1, 0);
    endtask

    task automatic test_abort();
        for (int i = 0; i < N; i++) dly[i] = 10;
        run_scenario(4'b1111, 0, 28, 0);  // layer 2 starts at 25, waiting at 28
        run_scenario(4'b0110, 0, 2, 0);   // abort on last RST cycle
    endtask

    task automatic test_ignored_inputs();
        for (int i = 0; i < N; i++) dly[i] = 6;
        run_scenario(4'b1111, 0, -1, 1);
        run_scenario(4'b0011, 9, -1, 1);
    endtask

    task automatic test_zero_mask();
        for (int i = 0; i < N; i++) dly[i] = 3;
        run_scenario(4'b0001, 0, -1, 0);  // finish in DONE first
        run_scenario(4'b0000, 0, -1, 0);
        run_scenario(4'b0000, 7, -1, 1);
        vectors++;
        if (started_cnt[0] + started_cnt[1] + started_cnt[2] + started_cnt[3] !== 0) begin
            miscompares++; $display("FAIL zero_mask_starts got=%0d want=0",
                                    started_cnt[0] + started_cnt[1] + started_cnt[2] + started_cnt[3]);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        int lim, ab;
        for (int n = 0; n < 30; n++) begin
            m   = N'($urandom);
            lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 10));
            for (int i = 0; i < N; i++)
                dly[i] = (lim != 0 && $urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
            ab = ($urandom_range(0, 3) == 0) ? -2 : -1;
            run_scenario(m, lim, ab, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk); #1;
        layer_done = '0;
        cmd_start = 1'b1; layer_mask = 4'b1111; timeout_limit = '0;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || irq !== 1'b0 || layer_resetn !== 1'b0 || cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset got busy=%b irq=%b lrn=%b cc=%0d want 0,0,0,0", busy, irq, layer_resetn, cycle_count);
        end
        for (int i = 0; i < N; i++) eng_started[i] = 1'b0;
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (irq !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                miscompares++; $display("FAIL after_mid_reset cyc=%0d got irq=%b busy=%b done=%b want 0,0,0", k, irq, busy, done);
            end
        end
        prev_cur = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            dly[i] = 1; eng_started[i] = 1'b0; eng_s[i] = 0; started_cnt[i] = 0;
        end
        test_reset();
        test_full_chain();
        test_sparse_mask();
        test_timeout();
        test_abort();
        test_ignored_inputs();
        test_zero_mask();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of chained layer engines (index 0 = first layer).
REQ-002 SHALL have parameter TO_W, default 24, width of the watchdog limit and counter.
REQ-003 SHALL have port clk  input  1  clock; reset resetn, synchronous, active-low; clock clk.
REQ-004 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-005 SHALL have port cmd_start  input  1  run request, sampled each cycle.
REQ-006 SHALL have port cmd_abort  input  1  abort request, sampled each cycle.
REQ-007 SHALL have port layer_mask  input  NUM_LAYERS  enabled layers, latched on accepted cmd_start.
REQ-008 SHALL have port timeout_limit  input  TO_W  per-layer watchdog limit in cycles, latched on accepted cmd_start; 0 = disabled.
REQ-009 SHALL have port layer_done  input  NUM_LAYERS  level done from each layer engine (sticky high once finished).
REQ-010 SHALL have port layer_start  output  NUM_LAYERS  one-hot single-cycle start pulse.
REQ-011 SHALL have port layer_resetn  output  1  active-low reset to all layer engines.
REQ-012 SHALL have ports busy, done, error, irq  output  1 each; cur_layer, err_layer  output  $clog2(NUM_LAYERS); cycle_count  output  32.

Function
REQ-013 SHALL implement states IDLE, RST, START, WAIT, DONE, ERROR, ABORT; all outputs registered or Moore-decoded from state.
REQ-014 cmd_start SHALL be accepted only in IDLE, DONE or ERROR; ignored otherwise.
REQ-015 Accepted cmd_start SHALL latch mask/limit, clear done, error, err_layer and cycle_count, enter RST.
REQ-016 RST SHALL last exactly 2 cycles with layer_resetn=0, clearing sticky layer_done of all engines.
REQ-017 Leaving RST SHALL enter START with cur_layer = lowest set bit of latched mask; mask==0 SHALL instead go directly to DONE.
REQ-018 START SHALL last 1 cycle with layer_start[cur_layer]=1, all other bits 0; then WAIT with watchdog cleared.
REQ-019 In WAIT, layer_done[cur_layer]=1 SHALL move to START of the next higher set mask bit, or to DONE if none; layer_done of other layers SHALL be ignored.
REQ-020 In WAIT, watchdog SHALL increment each cycle; when limit!=0 and watchdog==limit-1 without done, next state SHALL be ERROR with err_layer=cur_layer.
REQ-021 Done and timeout in the same cycle: done SHALL win.
REQ-022 cmd_abort in RST/START/WAIT SHALL enter ABORT (2 cycles, layer_resetn=0, layer_start=0), then IDLE; done and error stay 0.
REQ-023 cmd_abort and cmd_start together SHALL act as abort; in IDLE/DONE/ERROR both are ignored.
REQ-024 busy SHALL be 1 in RST, START, WAIT, ABORT; cycle_count SHALL increment each cycle in RST/START/WAIT and saturate at 2^32-1.
REQ-025 done (in DONE) and error (in ERROR) SHALL be sticky until next accepted cmd_start; irq SHALL pulse 1 cycle on entry to DONE or ERROR.
REQ-026 Latency: cmd_start at cycle 0 -> layer_resetn low cycles 1-2 -> layer_start cycle 3; layer_done at cycle t -> next layer_start or done/irq at t+1.

Reset
REQ-027 resetn=0 SHALL force IDLE, layer_start=0, layer_resetn=0, busy=done=error=irq=0, cur_layer=err_layer=0, cycle_count=0, watchdog=0.
REQ-028 layer_resetn SHALL be 1 in IDLE, START, WAIT, DONE, ERROR after reset deasserts.
REQ-029 Reset mid-run SHALL abandon the run with no irq.

Verification
REQ-030 mask=4'b1111, limit=0, each layer done 10 cycles after its start -> starts at cycles 3,14,25,36; done+irq at cycle 47; cycle_count=47.
REQ-031 mask=4'b1010 -> only layer_start[1] then layer_start[3]; layers 0,2 never started; done after layer 3 done.
REQ-032 mask=4'b0001, limit=5, layer_done never -> error and irq 5 cycles after WAIT entry, err_layer=0, layer_resetn stays 1.
REQ-033 cmd_abort during WAIT of layer 2 -> ABORT 2 cycles with layer_resetn=0, then IDLE, done=error=0, no irq.
REQ-034 cmd_start while busy, and layer_done[3] asserted while waiting on layer 1 -> both ignored, sequence unchanged.
REQ-035 mask=0 -> done+irq 3 cycles after cmd_start (after RST), no layer_start pulses; re-start from DONE clears done.
